axi_ar_arbiter: RTL
===================

Name: axi_ar_arbiter

Overview:
Arbitrates the shared AXI read-address (AR) channel of the interconnect between two masters: M0 (instruction fetch) and M1 (data access).
- Forwards the winner's AR payload to the address decoder, which asserts ARREADY_S per slave.
- Holds ownership of the read path until the last read beat completes (one outstanding read).
- Exports the current owner so the R-channel return mux can route data back.

Parameters:
ID_W, 4, master-side ARID width
IDS_W, 8, slave-side ARID width = 4-bit master tag + ID_W
ADDR_W, 32, address width
LEN_W, 4, ARLEN width

Ports:
ACLK  in  1  clock
ARESETn  in  1  asynchronous active-low reset
ARID_M0/ARID_M1  in  ID_W  master AR ID
ARADDR_M0/ARADDR_M1  in  ADDR_W  master AR address
ARLEN_M0/ARLEN_M1  in  LEN_W  burst length
ARSIZE_M0/ARSIZE_M1  in  3  burst size
ARBURST_M0/ARBURST_M1  in  2  burst type
ARVALID_M0/ARVALID_M1  in  1  master AR valid
ARREADY_M0/ARREADY_M1  out  1  master AR ready
ARID_S  out  IDS_W  {4'(owner index), ARID_Mx}
ARADDR_S, ARLEN_S, ARSIZE_S, ARBURST_S  out  as master  muxed payload to decoder
ARVALID_S  out  1  to decoder VALID
ARREADY_S  in  1  from decoder READY
RVALID_S, RREADY_S, RLAST_S  in  1 each  observed R handshake on shared return path
R_OWNER  out  1  owning master index (0=M0, 1=M1)
R_OWNER_VALID  out  1  high while a read is outstanding

Behaviour:
- State machine: IDLE, ADDR, DATA. Registers: state, grant (1b), last (1b, last master served).
- Reset (async, ARESETn=0): state=IDLE, grant=0, last=1 (M0 wins first tie). All outputs 0; ARID_S, ARADDR_S and other payload outputs are 0.
- IDLE
  - ARVALID_S=0; ARREADY_Mx=0.
  - Only one ARVALID_Mx high: grant=that master, next state ADDR.
  - Both high: grant=~last (round robin).
  - None high: stay IDLE.
  - Arbitration latency: exactly 1 cycle from ARVALID_Mx sampled high in IDLE to ARVALID_S high.
- ADDR
  - Payload and ARVALID_S are combinationally muxed from master[grant].
  - ARREADY_M[grant]=ARREADY_S; the other ARREADY_M=0.
  - On ARVALID_S & ARREADY_S: last<=grant, next state DATA.
  - Without a handshake: stay in ADDR, even if ARVALID drops (no regrant).
- DATA
  - ARVALID_S=0; both ARREADY_M=0.
  - R_OWNER=grant; R_OWNER_VALID=1.
  - On RVALID_S & RREADY_S & RLAST_S: next state IDLE.
  - Non-last beats keep state DATA.
- R_OWNER_VALID is 0 in IDLE/ADDR; R_OWNER holds grant in all states.
- RLAST handshakes in IDLE or ADDR are ignored.
- RLAST and a new ARVALID in the same cycle: go to IDLE; the new request is arbitrated next cycle, so the minimum turnaround is 2 cycles from RLAST to the next ARVALID_S.
- Starvation bound: with both masters requesting continuously, grants strictly alternate.
- Reset mid-transfer: immediately IDLE; the outstanding read is abandoned with no recovery.
- No combinational path from ARVALID_Mx to ARREADY_Mx except through ARREADY_S in ADDR.

Decomposition:
- Shared package/header (alongside the AXI defines):
  - ID, IDS, ADDR, LEN, SIZE and BURST width constants.
  - typedef enum logic [1:0] {IDLE, ADDR, DATA} ar_arb_state_t.
  - Master index constants M0=0, M1=1.
- One sub-module, rr_pick2: combinational 2-way round-robin selector (req[1:0], last → grant, any).

Test Plan:
1. Reset then ARVALID_M0=1, ARID_M0=4'h3, ARADDR=32'h0000_0100, ARREADY_S tied 1 → ARVALID_S high on cycle 2, ARID_S=8'h03, ARREADY_M0 pulses for 1 cycle, state DATA.
2. Both masters valid from reset → M0 first (ARID_S[7:4]=0). After RLAST, M1 next (ARID_S=8'h1x), then M0: strict alternation over 6 transactions.
3. ARREADY_S held low 5 cycles in ADDR while ARVALID_M1 rises → payload stays M0's and ARREADY_M1=0 throughout; handshake on cycle 6.
4. ARLEN=3 burst: 4 R beats, RLAST on the 4th → R_OWNER_VALID=1 for all 4 beats, drops the cycle after the last; no new grant before then.
5. RVALID&RREADY&RLAST coincident with a new ARVALID_M1 → IDLE next cycle, ARVALID_S for M1 one cycle later.
6. ARESETn pulled low in DATA mid-burst → all outputs 0 asynchronously. After release, a fresh ARVALID_M1 is granted normally (last=1 restored).

Source files
------------

// File: rtl/axi_ar_arbiter_pkg.sv
// Shared widths, state encoding and master indices for the AXI AR-channel arbiter.
package axi_ar_arbiter_pkg;

    localparam int unsigned AR_ID_W    = 4;
    localparam int unsigned AR_IDS_W   = 8;
    localparam int unsigned AR_ADDR_W  = 32;
    localparam int unsigned AR_LEN_W   = 4;
    localparam int unsigned AR_SIZE_W  = 3;
    localparam int unsigned AR_BURST_W = 2;

    localparam logic M0 = 1'b0;
    localparam logic M1 = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } ar_arb_state_t;

endpackage

// File: rtl/axi_ar_arbiter_rr_pick2.sv
// Two-way round-robin pick: a lone requester wins, a tie goes to the master not served last.
module rr_pick2
    import axi_ar_arbiter_pkg::*;
(
    input  logic [1:0] req_i,
    input  logic       last_i,
    output logic       grant_o,
    output logic       any_o
);

    // Select the winning master index from the request vector.
    always_comb begin
        grant_o = M0;
        case (req_i)
            2'b01:   grant_o = M0;
            2'b10:   grant_o = M1;
            2'b11:   grant_o = ~last_i;
            default: grant_o = M0;
        endcase
    end

    assign any_o = |req_i;

endmodule

// File: rtl/axi_ar_arbiter.sv
// Shares the AXI read-address channel between M0 (fetch) and M1 (data), holding
// ownership of the read path until the last R beat of the single outstanding read.
module axi_ar_arbiter
    import axi_ar_arbiter_pkg::*;
#(
    parameter int unsigned ID_W   = AR_ID_W,
    parameter int unsigned IDS_W  = AR_IDS_W,
    parameter int unsigned ADDR_W = AR_ADDR_W,
    parameter int unsigned LEN_W  = AR_LEN_W
) (
    input  logic                   ACLK,
    input  logic                   ARESETn,
    input  logic [ID_W-1:0]        ARID_M0,
    input  logic [ID_W-1:0]        ARID_M1,
    input  logic [ADDR_W-1:0]      ARADDR_M0,
    input  logic [ADDR_W-1:0]      ARADDR_M1,
    input  logic [LEN_W-1:0]       ARLEN_M0,
    input  logic [LEN_W-1:0]       ARLEN_M1,
    input  logic [AR_SIZE_W-1:0]   ARSIZE_M0,
    input  logic [AR_SIZE_W-1:0]   ARSIZE_M1,
    input  logic [AR_BURST_W-1:0]  ARBURST_M0,
    input  logic [AR_BURST_W-1:0]  ARBURST_M1,
    input  logic                   ARVALID_M0,
    input  logic                   ARVALID_M1,
    output logic                   ARREADY_M0,
    output logic                   ARREADY_M1,
    output logic [IDS_W-1:0]       ARID_S,
    output logic [ADDR_W-1:0]      ARADDR_S,
    output logic [LEN_W-1:0]       ARLEN_S,
    output logic [AR_SIZE_W-1:0]   ARSIZE_S,
    output logic [AR_BURST_W-1:0]  ARBURST_S,
    output logic                   ARVALID_S,
    input  logic                   ARREADY_S,
    input  logic                   RVALID_S,
    input  logic                   RREADY_S,
    input  logic                   RLAST_S,
    output logic                   R_OWNER,
    output logic                   R_OWNER_VALID
);

    localparam int unsigned TAG_W = IDS_W - ID_W;

    ar_arb_state_t state_q, state_d;
    logic          grant_q, grant_d;
    logic          last_q, last_d;
    logic          pick_grant_s;
    logic          pick_any_s;
    logic          sel_valid_s;
    logic          r_last_hs_s;

    rr_pick2 u_pick (
        .req_i   ({ARVALID_M1, ARVALID_M0}),
        .last_i  (last_q),
        .grant_o (pick_grant_s),
        .any_o   (pick_any_s)
    );

    assign sel_valid_s = (grant_q == M1) ? ARVALID_M1 : ARVALID_M0;
    assign r_last_hs_s = RVALID_S & RREADY_S & RLAST_S;

    // State, grant and round-robin history registers; last resets to M1 so M0 wins the first tie.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q <= IDLE;
            grant_q <= M0;
            last_q  <= M1;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
        end
    end

    // Next-state logic; grant only changes in IDLE, so a dropped ARVALID in ADDR never regrants.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (pick_any_s) begin
                    grant_d = pick_grant_s;
                    state_d = ADDR;
                end else begin
                    state_d = IDLE;
                end
            end
            ADDR: begin
                if (sel_valid_s && ARREADY_S) begin
                    last_d  = grant_q;
                    state_d = DATA;
                end else begin
                    state_d = ADDR;
                end
            end
            DATA: begin
                if (r_last_hs_s) begin
                    state_d = IDLE;
                end else begin
                    state_d = DATA;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output mux: the owner's payload is visible only in ADDR, everything else is driven to zero.
    always_comb begin
        ARREADY_M0    = 1'b0;
        ARREADY_M1    = 1'b0;
        ARID_S        = '0;
        ARADDR_S      = '0;
        ARLEN_S       = '0;
        ARSIZE_S      = '0;
        ARBURST_S     = '0;
        ARVALID_S     = 1'b0;
        R_OWNER_VALID = 1'b0;
        case (state_q)
            ADDR: begin
                ARVALID_S = sel_valid_s;
                if (grant_q == M1) begin
                    ARID_S     = {TAG_W'(grant_q), ARID_M1};
                    ARADDR_S   = ARADDR_M1;
                    ARLEN_S    = ARLEN_M1;
                    ARSIZE_S   = ARSIZE_M1;
                    ARBURST_S  = ARBURST_M1;
                    ARREADY_M1 = ARREADY_S;
                end else begin
                    ARID_S     = {TAG_W'(grant_q), ARID_M0};
                    ARADDR_S   = ARADDR_M0;
                    ARLEN_S    = ARLEN_M0;
                    ARSIZE_S   = ARSIZE_M0;
                    ARBURST_S  = ARBURST_M0;
                    ARREADY_M0 = ARREADY_S;
                end
            end
            DATA:    R_OWNER_VALID = 1'b1;
            IDLE:    R_OWNER_VALID = 1'b0;
            default: R_OWNER_VALID = 1'b0;
        endcase
    end

    assign R_OWNER = grant_q;

endmodule
